// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   Loadable one-shot down-counter used as a timeout/delay source. A start
//   value N is accepted over a valid/ready handshake while idle. The timer then
//   decrements it once every PRESCALE clocks until it reaches zero.
//   io_done pulses for exactly one cycle when zero is reached.
//
//   Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN
//     When defined, N is kept in a reload register and the timer restarts from
//     N after every DONE. Only io_cancel or reset return it to IDLE. A start
//     value of 0 still yields a single io_done and then IDLE.
//
// Parameters
//   WIDTH     count/load width in bits
//   PRESCALE  clocks per decrement (>= 1)
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high; overrides every other input
//   io_load_valid  start value on io_load_bits is valid
//   io_load_ready  timer can accept a start value (IDLE)
//   io_load_bits   start value N
//   io_cancel      abort a running count (ignored outside COUNT)
//   io_out         current count value
//   io_busy        1 while counting
//   io_done        one-cycle pulse when the count reaches zero
// ---------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_load_valid,
  output logic             io_load_ready,
  input  logic [WIDTH-1:0] io_load_bits,
  input  logic             io_cancel,
  output logic [WIDTH-1:0] io_out,
  output logic             io_busy,
  output logic             io_done
);

  // At least one prescaler bit, even when PRESCALE == 1.
  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]    ps_q, ps_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  logic load_fire;
  logic tick;

  assign load_fire = io_load_valid && (state_q == S_IDLE);
  assign tick      = (ps_q == PS_LAST);

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      ps_q     <= '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      ps_q     <= ps_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    ps_d     = ps_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load_fire) begin
          out_d = io_load_bits;
          ps_d  = '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          reload_d = io_load_bits;
`endif
          state_d = (io_load_bits != '0) ? S_COUNT : S_DONE;
        end
      end
      S_COUNT: begin
        // Cancel wins over a decrement on the same edge.
        if (io_cancel) begin
          state_d = S_IDLE;
          out_d   = '0;
          ps_d    = '0;
        end else if (tick) begin
          ps_d = '0;
          // out_q is never 0 here, but never wrap below zero regardless.
          if (out_q != '0) out_d = out_q - WIDTH'(1);
          if (out_q <= WIDTH'(1)) state_d = S_DONE;
        end else begin
          ps_d = ps_q + PW'(1);
        end
      end
      S_DONE: begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // A zero start value cannot be reloaded; fall back to one-shot.
        if (reload_q != '0) begin
          state_d = S_COUNT;
          out_d   = reload_q;
          ps_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
        out_d   = '0;
        ps_d    = '0;
      end
    endcase
  end

  // Outputs decode from state / registered count only.
  always_comb begin
    io_load_ready = (state_q == S_IDLE);
    io_busy       = (state_q == S_COUNT);
    io_done       = (state_q == S_DONE);
    io_out        = out_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Directed bench for countdown_timer. Two instances: PRESCALE=1 (u_p1),
//   driven from a vector table, and PRESCALE=3 (u_p3), driven by a short
//   hand-written sequence. Outputs are sampled 1 time unit after each edge.
//   With COUNTDOWN_TIMER_AUTO_RELOAD_EN defined, u_p1 runs the reload
//   sequence instead of the one-shot table.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // PRESCALE = 1 instance
  logic       rst1, vld1, cxl1;
  logic [3:0] bits1;
  logic       rdy1, busy1, done1;
  logic [3:0] out1;

  // PRESCALE = 3 instance
  logic       rst3, vld3, cxl3;
  logic [3:0] bits3;
  logic       rdy3, busy3, done3;
  logic [3:0] out3;

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clock(clk), .reset(rst1), .io_load_valid(vld1), .io_load_ready(rdy1),
    .io_load_bits(bits1), .io_cancel(cxl1), .io_out(out1),
    .io_busy(busy1), .io_done(done1));

  countdown_timer #(.WIDTH(4), .PRESCALE(3)) u_p3 (
    .clock(clk), .reset(rst3), .io_load_valid(vld3), .io_load_ready(rdy3),
    .io_load_bits(bits3), .io_cancel(cxl3), .io_out(out3),
    .io_busy(busy3), .io_done(done3));

  int checks = 0;
  int errors = 0;

  // Packed compare: {out[3:0], ready, busy, done}
  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got out=%0d rdy=%b busy=%b done=%b, want out=%0d rdy=%b busy=%b done=%b",
               nm, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [6:0] pk(input logic [3:0] o, input logic r, input logic b, input logic d);
    return {o, r, b, d};
  endfunction

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] bits;
    logic       cxl;
    logic [3:0] eout;
    logic       erdy;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic vld, input logic [3:0] bits, input logic cxl,
                     input logic [3:0] eout, input logic erdy, input logic ebusy, input logic edone);
    vec_t v;
    v.rst = rst; v.vld = vld; v.bits = bits; v.cxl = cxl;
    v.eout = eout; v.erdy = erdy; v.ebusy = ebusy; v.edone = edone;
    vq.push_back(v);
  endtask

  // Apply one cycle of p1 inputs, then sample after the edge.
  task automatic step1(input string nm, input logic rst, input logic vld, input logic [3:0] bits,
                       input logic cxl, input logic [6:0] exp);
    rst1 = rst; vld1 = vld; bits1 = bits; cxl1 = cxl;
    @(posedge clk); #1;
    chk(nm, pk(out1, rdy1, busy1, done1), exp);
  endtask

  task automatic step3(input string nm, input logic rst, input logic vld, input logic [3:0] bits,
                       input logic [6:0] exp);
    rst3 = rst; vld3 = vld; bits3 = bits; cxl3 = 1'b0;
    @(posedge clk); #1;
    chk(nm, pk(out3, rdy3, busy3, done3), exp);
  endtask

  initial begin
    rst1 = 1'b1; vld1 = 1'b0; bits1 = '0; cxl1 = 1'b0;
    rst3 = 1'b1; vld3 = 1'b0; bits3 = '0; cxl3 = 1'b0;

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // ---- one-shot table for PRESCALE=1 ----
    //  rst vld bits cxl | out rdy busy done
    add(1, 0, 0,  0,   0, 1, 0, 0);   // reset cycle 1
    add(1, 0, 0,  0,   0, 1, 0, 0);   // reset cycle 2
    // load 5: 5,4,3,2,1 then 0+done, ready again after
    add(0, 1, 5,  0,   5, 0, 1, 0);
    add(0, 0, 0,  0,   4, 0, 1, 0);
    add(0, 0, 0,  0,   3, 0, 1, 0);
    add(0, 0, 0,  0,   2, 0, 1, 0);
    add(0, 0, 0,  0,   1, 0, 1, 0);
    add(0, 0, 0,  0,   0, 0, 0, 1);
    add(0, 0, 0,  0,   0, 1, 0, 0);
    // load 0: straight to DONE, then IDLE
    add(0, 1, 0,  0,   0, 0, 0, 1);
    add(0, 0, 0,  0,   0, 1, 0, 0);
    // load 2, valid held with other data through COUNT and DONE: ignored
    add(0, 1, 2,  0,   2, 0, 1, 0);
    add(0, 1, 7,  0,   1, 0, 1, 0);
    add(0, 1, 7,  0,   0, 0, 0, 1);
    add(0, 1, 7,  0,   0, 1, 0, 0);   // valid during DONE not taken
    add(0, 0, 0,  0,   0, 1, 0, 0);
    // load 15 down to 9, cancel on the 9->8 edge
    add(0, 1, 15, 0,  15, 0, 1, 0);
    add(0, 0, 0,  0,  14, 0, 1, 0);
    add(0, 0, 0,  0,  13, 0, 1, 0);
    add(0, 0, 0,  0,  12, 0, 1, 0);
    add(0, 0, 0,  0,  11, 0, 1, 0);
    add(0, 0, 0,  0,  10, 0, 1, 0);
    add(0, 0, 0,  0,   9, 0, 1, 0);
    add(0, 0, 0,  1,   0, 1, 0, 0);   // cancelled, no done
    add(0, 0, 0,  1,   0, 1, 0, 0);   // cancel in IDLE ignored, no done
    // same again with reset in place of cancel
    add(0, 1, 15, 0,  15, 0, 1, 0);
    add(0, 0, 0,  0,  14, 0, 1, 0);
    add(0, 0, 0,  0,  13, 0, 1, 0);
    add(0, 0, 0,  0,  12, 0, 1, 0);
    add(0, 0, 0,  0,  11, 0, 1, 0);
    add(0, 0, 0,  0,  10, 0, 1, 0);
    add(0, 0, 0,  0,   9, 0, 1, 0);
    add(1, 0, 0,  0,   0, 1, 0, 0);   // reset mid-count
    add(0, 0, 0,  0,   0, 1, 0, 0);   // and no done afterwards
    // load 1, cancel on the 1->0 edge: cancel wins
    add(0, 1, 1,  0,   1, 0, 1, 0);
    add(0, 0, 0,  1,   0, 1, 0, 0);
    add(0, 0, 0,  0,   0, 1, 0, 0);

    foreach (vq[i]) begin
      step1($sformatf("p1_vec%0d", i), vq[i].rst, vq[i].vld, vq[i].bits, vq[i].cxl,
            pk(vq[i].eout, vq[i].erdy, vq[i].ebusy, vq[i].edone));
    end
`else
    // ---- auto-reload sequence for PRESCALE=1 ----
    step1("ar_rst0", 1, 0, 0, 0, pk(0, 1, 0, 0));
    step1("ar_rst1", 1, 0, 0, 0, pk(0, 1, 0, 0));
    step1("ar_c1", 0, 1, 3, 0, pk(3, 0, 1, 0));
    for (int c = 2; c <= 13; c++) begin
      int ph;
      ph = (c - 1) % 4;               // 0:3 1:2 2:1 3:done
      if (ph == 3) step1($sformatf("ar_c%0d", c), 0, 0, 0, 0, pk(0, 0, 0, 1));
      else         step1($sformatf("ar_c%0d", c), 0, 0, 0, 0, pk(4'(3 - ph), 0, 1, 0));
    end
    step1("ar_cancel", 0, 0, 0, 1, pk(0, 1, 0, 0));
    step1("ar_idle",   0, 0, 0, 0, pk(0, 1, 0, 0));
    step1("ar_n0",     0, 1, 0, 0, pk(0, 0, 0, 1));
    step1("ar_n0_idle",0, 0, 0, 0, pk(0, 1, 0, 0));
`endif
    rst1 = 1'b0; vld1 = 1'b0; cxl1 = 1'b0;

    // ---- PRESCALE=3, load 2 ----
    step3("p3_rst0", 1, 0, 0, pk(0, 1, 0, 0));
    step3("p3_rst1", 1, 0, 0, pk(0, 1, 0, 0));
    step3("p3_c1", 0, 1, 2, pk(2, 0, 1, 0));
    step3("p3_c2", 0, 0, 0, pk(2, 0, 1, 0));
    step3("p3_c3", 0, 0, 0, pk(2, 0, 1, 0));
    step3("p3_c4", 0, 0, 0, pk(1, 0, 1, 0));
    step3("p3_c5", 0, 0, 0, pk(1, 0, 1, 0));
    step3("p3_c6", 0, 0, 0, pk(1, 0, 1, 0));
    step3("p3_c7", 0, 0, 0, pk(0, 0, 0, 1));
`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    step3("p3_c8", 0, 0, 0, pk(0, 1, 0, 0));
`else
    step3("p3_c8", 0, 0, 0, pk(2, 0, 1, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
